// File: rtl/encoder_sequencer_if.sv
// encoder_sequencer_if: control bundle between the sequencer and the datapath/test side.
// start/hold flow into the sequencer; strobes, step select, round and file index flow out.
interface encoder_sequencer_if;
  logic       start;
  logic       hold;
  logic       busy;
  logic       read_file;
  logic       load_en;
  logic       step_en;
  logic [2:0] step_sel;
  logic [4:0] round_num;
  logic       write_file;
  logic [9:0] file_index;
  logic       done;

  modport master (
    output start, hold,
    input  busy, read_file, load_en, step_en,
    input  step_sel, round_num, write_file,
    input  file_index, done
  );

  modport slave (
    input  start, hold,
    output busy, read_file, load_en, step_en,
    output step_sel, round_num, write_file,
    output file_index, done
  );
endinterface

// File: rtl/encoder_sequencer.sv
// encoder_sequencer: walks NUM_FILES files through read, load, NUM_ROUNDS x 5 steps, write.
// Ports: clk, rst (sync active-high), bus (slave: start/hold in, strobes/counters out).
module encoder_sequencer #(
  parameter int NUM_ROUNDS = 24,
  parameter int NUM_FILES  = 64
) (
  input logic                clk,
  input logic                rst,
  encoder_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, READ, LOAD, STEP, WRITE, NEXT, DONE
  } state_t;

  localparam logic [4:0] LAST_RND  = 5'(NUM_ROUNDS - 1);
  localparam logic [9:0] LAST_FILE = 10'(NUM_FILES - 1);

  state_t     state;
  logic       busy_q;
  logic       rd_q;
  logic       ld_q;
  logic       st_q;
  logic       wr_q;
  logic       done_q;
  logic [2:0] sel_q;
  logic [4:0] rnd_q;
  logic [9:0] idx_q;

  // Pulses are computed for the state being entered, so every
  // output is a flop that lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      rd_q   <= 1'b0;
      ld_q   <= 1'b0;
      st_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      sel_q  <= '0;
      rnd_q  <= '0;
      idx_q  <= '0;
    end else begin
      rd_q   <= 1'b0;
      ld_q   <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= READ;
            busy_q <= 1'b1;
            rd_q   <= 1'b1;
            idx_q  <= '0;
          end
        end
        READ: begin
          state <= LOAD;
          ld_q  <= 1'b1;
        end
        LOAD: begin
          state <= STEP;
          st_q  <= 1'b1;
          sel_q <= '0;
          rnd_q <= '0;
        end
        STEP: begin
          if (!bus.hold) begin
            if (sel_q == 3'd4) begin
              // Final step of the final round: counters stay put.
              if (rnd_q == LAST_RND) begin
                state <= WRITE;
                st_q  <= 1'b0;
                wr_q  <= 1'b1;
              end else begin
                sel_q <= '0;
                rnd_q <= rnd_q + 5'd1;
              end
            end else begin
              sel_q <= sel_q + 3'd1;
            end
          end
        end
        WRITE: begin
          state <= NEXT;
        end
        NEXT: begin
          if (idx_q == LAST_FILE) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= READ;
            rd_q  <= 1'b1;
            idx_q <= idx_q + 10'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          st_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.read_file  = rd_q;
  assign bus.load_en    = ld_q;
  // A stalled step must not touch the state register in the same
  // cycle, so the step strobe is gated by hold directly.
  assign bus.step_en    = st_q & ~bus.hold;
  assign bus.step_sel   = sel_q;
  assign bus.round_num  = rnd_q;
  assign bus.write_file = wr_q;
  assign bus.file_index = idx_q;
  assign bus.done       = done_q;

endmodule

// File: doc/encoder_sequencer.md
ENCODER_SEQUENCER -- requirements
Module: encoder_sequencer

Interface
REQ-001 Parameter NUM_ROUNDS, default 24, number of permutation rounds per file (1..31).
REQ-002 Parameter NUM_FILES, default 64, number of input files processed per run (1..1024).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 hold  input  1  stall request, honoured only in STEP.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 read_file  output  1  one-cycle pulse requesting the file loader read file file_index.
REQ-009 load_en  output  1  one-cycle pulse; the state register captures the loaded 1600-bit input.
REQ-010 step_en  output  1  high when the selected step operation shall update the state register this cycle.
REQ-011 step_sel  output  3  step select: 0 theta, 1 rho, 2 pi, 3 chi, 4 iota; values 5..7 never driven.
REQ-012 round_num  output  5  current round index (0..NUM_ROUNDS-1), used by iota for the round constant.
REQ-013 write_file  output  1  one-cycle pulse to the file writer; the writer names its output from file_index.
REQ-014 file_index  output  10  index of the file currently processed.
REQ-015 done  output  1  one-cycle pulse when all NUM_FILES files have been written.

Function
REQ-016 FSM states: IDLE, READ, LOAD, STEP, WRITE, NEXT, DONE; registered Moore outputs, decoded from state and counters only.
REQ-017 IDLE: when start=1, file_index<=0 and go to READ; otherwise remain.
REQ-018 READ: read_file=1 for exactly this cycle; unconditionally go to LOAD.
REQ-019 LOAD: load_en=1 for exactly this cycle; round_num<=0, step_sel<=0; go to STEP.
REQ-020 STEP with hold=0: step_en=1; step_sel advances 0->1->2->3->4; from 4 it wraps to 0 and round_num increments.
REQ-021 STEP with hold=1: step_en=0; step_sel and round_num frozen; no state change.
REQ-022 STEP exit: when step_sel=4, round_num=NUM_ROUNDS-1 and hold=0, go to WRITE; round_num and step_sel are not advanced past these final values.
REQ-023 WRITE: write_file=1 for exactly this cycle, with file_index stable; go to NEXT.
REQ-024 NEXT: if file_index=NUM_FILES-1 go to DONE; else file_index increments by 1 and go to READ.
REQ-025 DONE: done=1 for exactly this cycle; go to IDLE; file_index retains its final value.
REQ-026 start outside IDLE is ignored; hold outside STEP is ignored.
REQ-027 Latency per file with hold=0: 5*NUM_ROUNDS+4 cycles (124 at defaults); done occurs N*(5*NUM_ROUNDS+4)+1 cycles after the sampling edge of start.
REQ-028 read_file, load_en, step_en, write_file and done are mutually exclusive in every cycle.

Reset
REQ-029 rst=1 forces IDLE at the next edge in any state, including mid-STEP or WRITE; it takes priority over start and hold.
REQ-030 Reset values: busy=0, read_file=0, load_en=0, step_en=0, step_sel=0, round_num=0, write_file=0, file_index=0, done=0.
REQ-031 A run aborted by reset issues no further write_file and no done; a new start begins again at file_index=0.

Verification
REQ-032 Defaults, hold=0, start pulse -> file 0: read_file at cycle 1, load_en at 2, step_en at 3..122, write_file at 123 with file_index=0; done at cycle 64*124+1=7937; exactly 64 write_file pulses with indices 0..63.
REQ-033 NUM_ROUNDS=2, NUM_FILES=2 -> step_sel sequence 0,1,2,3,4,0,1,2,3,4 with round_num 0 for the first five steps and 1 for the next five; write_file with file_index 0 then 1; done at cycle 2*14+1=29.
REQ-034 hold=1 for 3 cycles while step_sel=2 in round 5 -> step_en=0 for those 3 cycles, step_sel stays 2, round_num stays 5; every later event shifts by exactly 3 cycles.
REQ-035 start asserted continuously during a run -> no restart, file_index is never reset mid-run; after done the FSM returns to IDLE, samples start again and begins a new run at file_index=0.
REQ-036 rst pulsed while in STEP (file 3, round 10) -> next cycle all outputs equal their reset values; no write_file pulse for file 3; a later start reads file 0 first.
